// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register plus ALU, write-register select and
// branch/jump redirect resolution. All outputs come from the registered fields.
module ex_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PCPlus4_in,
  input  logic [31:0] imm_signExtended,
  input  logic [31:0] imm_zeroExtended,
  input  logic [31:0] rs_reg,
  input  logic [31:0] rt_reg,
  input  logic [4:0]  rt_addr_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [4:0]  shamt_in,
  input  logic [25:0] address_Jtype_in,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        MemWriteD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        RegDstD,
  input  logic [5:0]  ALUopD,
  input  logic [5:0]  ALUfunctD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [31:0] ALUOutE,
  output logic [31:0] WriteDataE,
  output logic [4:0]  WriteRegE,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE
);

  // opcodes
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  // R-type functs
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [25:0] addr_j;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        reg_dst;
    logic [5:0]  op;
    logic [5:0]  funct;
  } idex_t;

  idex_t idex_d, idex_q;

  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        br_taken, jmp_abs, jmp_reg;

  // gather decode-stage inputs into the register image
  always_comb begin
    idex_d            = '0;
    idex_d.pc4        = PCPlus4_in;
    idex_d.imm_s      = imm_signExtended;
    idex_d.imm_z      = imm_zeroExtended;
    idex_d.rs         = rs_reg;
    idex_d.rt         = rt_reg;
    idex_d.rt_addr    = rt_addr_in;
    idex_d.rd_addr    = rd_addr_in;
    idex_d.shamt      = shamt_in;
    idex_d.addr_j     = address_Jtype_in;
    idex_d.reg_write  = RegWriteD;
    idex_d.mem_to_reg = MemtoRegD;
    idex_d.mem_write  = MemWriteD;
    idex_d.branch     = BranchD;
    idex_d.jump       = JumpD;
    idex_d.reg_dst    = RegDstD;
    idex_d.op         = ALUopD;
    idex_d.funct      = ALUfunctD;
  end

  // ID/EX register: reset beats flush beats stall; an all-zero image is a sll $0 bubble
  always_ff @(posedge CLK) begin
    if (RESET)        idex_q <= '0;
    else if (FlushE)  idex_q <= '0;
    else if (!StallE) idex_q <= idex_d;
  end

  // second operand: rt for R-type, zero-extended imm for logical-immediate ops, else sign-extended
  always_comb begin
    alu_b = idex_q.imm_s;
    if (idex_q.op == OP_R) alu_b = idex_q.rt;
    else if (idex_q.op == OP_ANDI || idex_q.op == OP_ORI || idex_q.op == OP_XORI) alu_b = idex_q.imm_z;
  end

  // ALU; unrecognised op/funct yields zero
  always_comb begin
    alu_out = '0;
    case (idex_q.op)
      OP_R: begin
        case (idex_q.funct)
          F_ADD, F_ADDU: alu_out = idex_q.rs + alu_b;
          F_SUB, F_SUBU: alu_out = idex_q.rs - alu_b;
          F_AND:         alu_out = idex_q.rs & alu_b;
          F_OR:          alu_out = idex_q.rs | alu_b;
          F_XOR:         alu_out = idex_q.rs ^ alu_b;
          F_NOR:         alu_out = ~(idex_q.rs | alu_b);
          F_SLT:         alu_out = {31'd0, $signed(idex_q.rs) < $signed(idex_q.rt)};
          F_SLL:         alu_out = idex_q.rt << idex_q.shamt;
          F_SRL:         alu_out = idex_q.rt >> idex_q.shamt;
          F_SRA:         alu_out = $signed(idex_q.rt) >>> idex_q.shamt;
          F_SLLV:        alu_out = idex_q.rt << idex_q.rs[4:0];
          F_SRLV:        alu_out = idex_q.rt >> idex_q.rs[4:0];
          F_SRAV:        alu_out = $signed(idex_q.rt) >>> idex_q.rs[4:0];
          default:       alu_out = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_out = idex_q.rs + alu_b;
      OP_ANDI:                         alu_out = idex_q.rs & alu_b;
      OP_ORI:                          alu_out = idex_q.rs | alu_b;
      OP_XORI:                         alu_out = idex_q.rs ^ alu_b;
      OP_JAL:                          alu_out = idex_q.pc4;
      default:                         alu_out = '0;
    endcase
  end

  // redirect resolution; jumps are qualified by the decoded jump flag like branches
  always_comb begin
    br_taken  = idex_q.branch &
                (((idex_q.op == OP_BEQ) && (idex_q.rs == idex_q.rt)) ||
                 ((idex_q.op == OP_BNE) && (idex_q.rs != idex_q.rt)));
    jmp_abs   = idex_q.jump && (idex_q.op == OP_J || idex_q.op == OP_JAL);
    jmp_reg   = idex_q.jump && (idex_q.op == OP_R) && (idex_q.funct == F_JR);
    PCSrcE    = br_taken | jmp_abs | jmp_reg;
    PCTargetE = idex_q.pc4;
    if (jmp_reg)       PCTargetE = idex_q.rs;
    else if (jmp_abs)  PCTargetE = {idex_q.pc4[31:28], idex_q.addr_j, 2'b00};
    else if (br_taken) PCTargetE = idex_q.pc4 + {idex_q.imm_s[29:0], 2'b00};
  end

  assign ALUOutE    = alu_out;
  assign WriteDataE = idex_q.rt;
  assign WriteRegE  = (idex_q.op == OP_JAL) ? 5'd31 : (idex_q.reg_dst ? idex_q.rd_addr : idex_q.rt_addr);
  assign RegWriteE  = idex_q.reg_write;
  assign MemtoRegE  = idex_q.mem_to_reg;
  assign MemWriteE  = idex_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes hand-computed expectations at
// each negedge; the monitor pops one after the following posedge and compares.
module tb_ex_stage;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PCPlus4_in, imm_signExtended, imm_zeroExtended, rs_reg, rt_reg;
  logic [4:0]  rt_addr_in, rd_addr_in, shamt_in;
  logic [25:0] address_Jtype_in;
  logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD;
  logic [5:0]  ALUopD, ALUfunctD;
  logic        StallE, FlushE;
  logic [31:0] ALUOutE, WriteDataE, PCTargetE;
  logic [4:0]  WriteRegE;
  logic        RegWriteE, MemtoRegE, MemWriteE, PCSrcE;

  typedef struct {
    string       tag;
    logic [31:0] alu, wd, tgt;
    logic [4:0]  wr;
    logic        rw, m2r, mw, src;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_stage dut (
    .CLK(CLK), .RESET(RESET), .PCPlus4_in(PCPlus4_in),
    .imm_signExtended(imm_signExtended), .imm_zeroExtended(imm_zeroExtended),
    .rs_reg(rs_reg), .rt_reg(rt_reg), .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in),
    .shamt_in(shamt_in), .address_Jtype_in(address_Jtype_in),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .RegDstD(RegDstD),
    .ALUopD(ALUopD), .ALUfunctD(ALUfunctD), .StallE(StallE), .FlushE(FlushE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: one expectation per clock once the stimulus has queued it
  initial forever begin
    @(posedge CLK); #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ALUOutE"},    ALUOutE,    e.alu);
      chk({e.tag, ".WriteDataE"}, WriteDataE, e.wd);
      chk({e.tag, ".WriteRegE"},  {27'd0, WriteRegE}, {27'd0, e.wr});
      chk({e.tag, ".RegWriteE"},  {31'd0, RegWriteE}, {31'd0, e.rw});
      chk({e.tag, ".MemtoRegE"},  {31'd0, MemtoRegE}, {31'd0, e.m2r});
      chk({e.tag, ".MemWriteE"},  {31'd0, MemWriteE}, {31'd0, e.mw});
      chk({e.tag, ".PCSrcE"},     {31'd0, PCSrcE},    {31'd0, e.src});
      chk({e.tag, ".PCTargetE"},  PCTargetE,  e.tgt);
    end
  end

  task automatic clr();
    RESET = 0; StallE = 0; FlushE = 0;
    PCPlus4_in = 0; imm_signExtended = 0; imm_zeroExtended = 0; rs_reg = 0; rt_reg = 0;
    rt_addr_in = 0; rd_addr_in = 0; shamt_in = 0; address_Jtype_in = 0;
    RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0; RegDstD = 0;
    ALUopD = 0; ALUfunctD = 0;
  endtask

  task automatic nxt();
    @(negedge CLK);
    clr();
  endtask

  task automatic push(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [4:0] wr, input logic rw, input logic m2r, input logic mw,
                      input logic src, input logic [31:0] tgt);
    exp_t e;
    e.tag = tag; e.alu = alu; e.wd = wd; e.wr = wr; e.rw = rw;
    e.m2r = m2r; e.mw = mw; e.src = src; e.tgt = tgt;
    sb.push_back(e);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] pc4);
    ALUopD = 6'b000000; ALUfunctD = f; rs_reg = rs; rt_reg = rt; rd_addr_in = rd;
    shamt_in = sh; PCPlus4_in = pc4; RegDstD = 1; RegWriteD = 1;
  endtask

  initial begin
    clr();
    RESET = 1;
    nxt(); RESET = 1;                       push("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); rtype(6'b100000, 7, 5, 3, 0, 32'h20);
           push("add", 12, 5, 3, 1, 0, 0, 0, 32'h20);
    nxt(); rtype(6'b100000, 32'hFFFFFFFF, 1, 3, 0, 32'h24);
           push("add_wrap", 0, 1, 3, 1, 0, 0, 0, 32'h24);
    nxt(); rtype(6'b100010, 0, 1, 4, 0, 32'h28);
           push("sub", 32'hFFFFFFFF, 1, 4, 1, 0, 0, 0, 32'h28);
    nxt(); rtype(6'b000011, 32'h1F, 32'h80000000, 5, 4, 32'h2C);
           push("sra", 32'hF8000000, 32'h80000000, 5, 1, 0, 0, 0, 32'h2C);
    nxt(); rtype(6'b000110, 32'h24, 32'h80000000, 6, 0, 32'h30);
           push("srlv", 32'h08000000, 32'h80000000, 6, 1, 0, 0, 0, 32'h30);
    nxt(); rtype(6'b101010, 32'hFFFFFFFF, 1, 7, 0, 32'h34);
           push("slt_neg", 1, 1, 7, 1, 0, 0, 0, 32'h34);
    nxt(); rtype(6'b101010, 5, 5, 7, 0, 32'h38);
           push("slt_eq", 0, 5, 7, 1, 0, 0, 0, 32'h38);
    nxt(); rtype(6'b100111, 0, 32'hFF, 8, 0, 32'h3C);
           push("nor", 32'hFFFFFF00, 32'hFF, 8, 1, 0, 0, 0, 32'h3C);
    nxt(); rtype(6'b111111, 3, 4, 9, 0, 32'h40);
           push("bad_funct", 0, 4, 9, 1, 0, 0, 0, 32'h40);
    // ori: zero-extended immediate, destination is rt
    nxt(); ALUopD = 6'b001101; rs_reg = 32'hF0; imm_zeroExtended = 32'h0000FF00;
           imm_signExtended = 32'hFFFFFF00; rt_addr_in = 8; rd_addr_in = 20; RegWriteD = 1;
           PCPlus4_in = 32'h44;
           push("ori", 32'hFFF0, 0, 8, 1, 0, 0, 0, 32'h44);
    nxt(); ALUopD = 6'b100011; rs_reg = 32'h1000; imm_signExtended = 32'hFFFFFFFC;
           imm_zeroExtended = 32'hFFFC; rt_addr_in = 9; rt_reg = 32'h55; RegWriteD = 1;
           MemtoRegD = 1; PCPlus4_in = 32'h48;
           push("lw", 32'hFFC, 32'h55, 9, 1, 1, 0, 0, 32'h48);
    nxt(); ALUopD = 6'b101011; rs_reg = 32'h200; imm_signExtended = 8; rt_reg = 32'hDEADBEEF;
           rt_addr_in = 10; MemWriteD = 1; PCPlus4_in = 32'h4C;
           push("sw", 32'h208, 32'hDEADBEEF, 10, 0, 0, 1, 0, 32'h4C);
    nxt(); ALUopD = 6'b000100; BranchD = 1; rs_reg = 9; rt_reg = 9; PCPlus4_in = 32'h100;
           imm_signExtended = 32'hFFFFFFFF;
           push("beq", 0, 9, 0, 0, 0, 0, 1, 32'hFC);
    nxt(); ALUopD = 6'b000101; BranchD = 1; rs_reg = 9; rt_reg = 9; PCPlus4_in = 32'h100;
           imm_signExtended = 32'hFFFFFFFF;
           push("bne", 0, 9, 0, 0, 0, 0, 0, 32'h100);
    nxt(); ALUopD = 6'b000011; JumpD = 1; RegWriteD = 1; PCPlus4_in = 32'h40000010;
           address_Jtype_in = 26'h10;
           push("jal", 32'h40000010, 0, 31, 1, 0, 0, 1, 32'h40000040);
    nxt(); ALUopD = 6'b000000; ALUfunctD = 6'b001000; JumpD = 1; rs_reg = 32'h1234;
           PCPlus4_in = 32'h60;
           push("jr", 0, 0, 0, 0, 0, 0, 1, 32'h1234);
    // stall holds an 'and' across two cycles of changing inputs
    nxt(); rtype(6'b100100, 32'hF0F0, 32'hFF00, 11, 0, 32'h50);
           push("and", 32'hF000, 32'hFF00, 11, 1, 0, 0, 0, 32'h50);
    for (int i = 0; i < 2; i++) begin
      nxt(); rtype(6'b100000, 32'h111 * (i + 1), 32'h222, 12, 0, 32'h54); StallE = 1;
             push("stall", 32'hF000, 32'hFF00, 11, 1, 0, 0, 0, 32'h50);
    end
    nxt(); rtype(6'b100000, 1, 2, 13, 0, 32'h58); StallE = 1; FlushE = 1;
           push("flush_stall", 0, 0, 0, 0, 0, 0, 0, 0);
    // reset while a lw is in flight
    nxt(); ALUopD = 6'b100011; rs_reg = 32'h100; imm_signExtended = 4; rt_addr_in = 2;
           rt_reg = 7; RegWriteD = 1; MemtoRegD = 1; PCPlus4_in = 32'h60;
           push("lw2", 32'h104, 7, 2, 1, 1, 0, 0, 32'h60);
    nxt(); ALUopD = 6'b100011; rs_reg = 32'h100; imm_signExtended = 4; rt_addr_in = 2;
           rt_reg = 7; RegWriteD = 1; MemtoRegD = 1; PCPlus4_in = 32'h60; RESET = 1;
           push("reset_lw", 0, 0, 0, 0, 0, 0, 0, 0);
    // reset wins over a concurrent stall
    nxt(); rtype(6'b100101, 1, 2, 14, 0, 32'h64);
           push("or", 3, 2, 14, 1, 0, 0, 0, 32'h64);
    nxt(); rtype(6'b100101, 4, 8, 15, 0, 32'h68); StallE = 1; RESET = 1;
           push("reset_stall", 0, 0, 0, 0, 0, 0, 0, 0);
    nxt();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
